// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: bus widths,
// FSM state encodings, default timeout and the master request bundle.
package wb_arbiter_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  // Cycles of unacked strobe before the master gets an error.
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned TO_CW           = 8;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbGnt0 = 2'd1,
    ArbGnt1 = 2'd2
  } arb_state_e;

  // Everything a master drives towards the slave.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
    logic [SW-1:0] sel;
    logic          stb;
    logic          cyc;
  } wb_req_t;

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus-timeout watchdog. Counts consecutive strobe cycles without ack and
// flags expire in the TIMEOUT-th such cycle; the arbiter uses expire both
// as the master's err pulse and to kill the slave strobe.
module wb_arb_timeout
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT  // legal 1..255
) (
  input  logic clk,
  input  logic rst,     // async, active low
  input  logic clr,     // arbiter idle
  input  logic stb,     // granted master's raw strobe
  input  logic ack,     // slave ack
  output logic expire
);

  // cnt holds the number of completed unacked strobe cycles, so the
  // current cycle is number cnt+1; it expires when that reaches TIMEOUT.
  localparam logic [TO_CW-1:0] LAST = 8'(TIMEOUT - 1);

  logic [TO_CW-1:0] cnt;

  // An ack in the expiry cycle wins, so no err and no strobe kill then.
  assign expire = stb & ~ack & ~clr & (cnt == LAST);

  // Count unacked strobe cycles; restart after every ack, gap or expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               cnt <= '0;
    else if (clr | ack | ~stb | expire)     cnt <= '0;
    else                                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter (m0 = data bus, m1 = instruction
// bus). Grant is held for the whole cyc burst, one idle cycle separates
// owners, and a watchdog returns err to a master whose slave never acks.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN (alternate on contention
// instead of fixed m0 > m1 priority).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,        // async, active low
  // master 0 (data)
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_stb_i,
  input  logic          m0_cyc_i,
  output logic [DW-1:0] m0_data_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  // master 1 (instruction)
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_stb_i,
  input  logic          m1_cyc_i,
  output logic [DW-1:0] m1_data_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  // slave
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_data_o,
  output logic          s_we_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_stb_o,
  output logic          s_cyc_o,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_ack_i
);

  arb_state_e state, state_nxt, both_pick;
  wb_req_t    req0, req1, req_g;
  logic       gnt, expire;

  assign req0  = {m0_addr_i, m0_data_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i};
  assign req1  = {m1_addr_i, m1_data_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i};
  assign gnt   = (state != ArbIdle);
  assign req_g = (state == ArbGnt1) ? req1 : req0;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // 0 = m0 was granted last, 1 = m1; contention goes to the other one.
  logic last_gnt;

  // Remember the owner of each new grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         last_gnt <= 1'b0;
    else if (state == ArbIdle && state_nxt != ArbIdle) last_gnt <= (state_nxt == ArbGnt1);
  end

  assign both_pick = last_gnt ? ArbGnt0 : ArbGnt1;
`else
  assign both_pick = ArbGnt0;
`endif

  // State register; reset drops the grant (and so s_cyc/s_stb) at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ArbIdle;
    else      state <= state_nxt;
  end

  // Arbitrate only from IDLE; a grant lasts until its owner drops cyc.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ArbIdle: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = both_pick;
        else if (m0_cyc_i)        state_nxt = ArbGnt0;
        else if (m1_cyc_i)        state_nxt = ArbGnt1;
      end
      ArbGnt0: if (!m0_cyc_i) state_nxt = ArbIdle;
      ArbGnt1: if (!m1_cyc_i) state_nxt = ArbIdle;
      default: state_nxt = ArbIdle;
    endcase
  end

  // Mirror the owner onto the slave and route ack/data/err back to it only.
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    if (gnt) begin
      s_addr_o = req_g.addr;
      s_data_o = req_g.data;
      s_we_o   = req_g.we;
      s_sel_o  = req_g.sel;
      s_stb_o  = req_g.stb & ~expire;
      s_cyc_o  = req_g.cyc;
    end
    if (state == ArbGnt0) begin
      m0_data_o = s_data_i;
      m0_ack_o  = s_ack_i;
      m0_err_o  = expire;
    end
    if (state == ArbGnt1) begin
      m1_data_o = s_data_i;
      m1_ack_o  = s_ack_i;
      m1_err_o  = expire;
    end
  end

  wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (~gnt),
    .stb    (gnt & req_g.stb),
    .ack    (s_ack_i),
    .expire (expire)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a transaction-level model predicts every
// output for each cycle, the driver queues the prediction, and a monitor
// on the falling edge compares it with the DUT.
module tb_wb_arbiter;

  localparam int TO = 4;
`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] a [2];
  logic [31:0] d [2];
  logic [3:0]  sl[2];
  logic        w [2];
  logic        st[2];
  logic        cy[2];
  logic [31:0] s_dat;
  logic        s_ack;

  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]  s_sel_o;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst_n),
    .m0_addr_i(a[0]), .m0_data_i(d[0]), .m0_we_i(w[0]), .m0_sel_i(sl[0]),
    .m0_stb_i(st[0]), .m0_cyc_i(cy[0]),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(a[1]), .m1_data_i(d[1]), .m1_we_i(w[1]), .m1_sel_i(sl[1]),
    .m1_stb_i(st[1]), .m1_cyc_i(cy[1]),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_data_i(s_dat), .s_ack_i(s_ack)
  );

  typedef struct packed {
    logic [31:0] m0_data, m1_data, s_addr, s_data;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_we, s_stb, s_cyc;
    logic [3:0]  s_sel;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, how many strobe cycles in a row
  // have gone unanswered, and who won last time.
  int owner = -1;
  int unacked = 0;
  int last = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; unacked = 0; last = 0;
  endtask

  // Bus rules applied at a rising edge with the inputs of the ending cycle.
  task automatic model_edge();
    bit timed_out;
    if (!rst_n) begin model_reset(); return; end
    if (owner < 0) begin
      unacked = 0;
      if (cy[0] && cy[1]) owner = RR ? (last == 0 ? 1 : 0) : 0;
      else if (cy[0])     owner = 0;
      else if (cy[1])     owner = 1;
      if (owner >= 0) last = owner;
    end else if (!cy[owner]) begin
      owner = -1; unacked = 0;
    end else begin
      timed_out = st[owner] && !s_ack && (unacked + 1 == TO);
      if (st[owner] && !s_ack && !timed_out) unacked++;
      else                                   unacked = 0;
    end
  endtask

  // Prediction for the current cycle given the inputs now applied.
  task automatic push_exp();
    exp_t e;
    bit   to_now;
    e = '0;
    if (rst_n && owner >= 0) begin
      to_now  = st[owner] && !s_ack && (unacked + 1 == TO);
      e.s_addr = a[owner];
      e.s_data = d[owner];
      e.s_we   = w[owner];
      e.s_sel  = sl[owner];
      e.s_stb  = st[owner] && !to_now;
      e.s_cyc  = cy[owner];
      if (owner == 0) begin e.m0_ack = s_ack; e.m0_data = s_dat; e.m0_err = to_now; end
      else            begin e.m1_ack = s_ack; e.m1_data = s_dat; e.m1_err = to_now; end
    end
    sbq.push_back(e);
  endtask

  task automatic advance();
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_m(input int i, input bit c, input bit s, input bit we,
                       input logic [31:0] ad, input logic [31:0] dt);
    cy[i] = c; st[i] = s; w[i] = we; a[i] = ad; d[i] = dt; sl[i] = 4'hF;
  endtask

  // Monitor: compare every output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("m0_data", m0_data_o, e.m0_data);
        chk("m0_ack", 32'(m0_ack_o), 32'(e.m0_ack));
        chk("m0_err", 32'(m0_err_o), 32'(e.m0_err));
        chk("m1_data", m1_data_o, e.m1_data);
        chk("m1_ack", 32'(m1_ack_o), 32'(e.m1_ack));
        chk("m1_err", 32'(m1_err_o), 32'(e.m1_err));
        chk("s_addr", s_addr_o, e.s_addr);
        chk("s_data", s_data_o, e.s_data);
        chk("s_we", 32'(s_we_o), 32'(e.s_we));
        chk("s_sel", 32'(s_sel_o), 32'(e.s_sel));
        chk("s_stb", 32'(s_stb_o), 32'(e.s_stb));
        chk("s_cyc", 32'(s_cyc_o), 32'(e.s_cyc));
      end
    end
  end

  initial begin
    bit dead;
    rst_n = 1'b0;
    s_ack = 1'b0; s_dat = '0;
    for (int i = 0; i < 2; i++) set_m(i, 1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(posedge clk); #1;

    // Reset state: outputs stay 0 even with both masters requesting.
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h1);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h2);
    advance();
    advance();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    advance();

    // m1 read alone, slave acks in its 2nd granted cycle with DEADBEEF.
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, '0);
    advance();
    advance();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    advance();
    s_ack = 1'b0; set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    advance();
    advance();

    // Contention, then m0 holds cyc for three acked writes while m1 waits.
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hA0);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h80, '0);
    advance();
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      a[0] = 32'h10 + 32'(4 * k); d[0] = 32'hA0 + 32'(k);
      advance();
    end
    s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) advance();
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    advance();
    advance();

    // Four contention rounds; fixed priority or alternating, per build.
    for (int r = 0; r < 4; r++) begin
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h300, '0);
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h400, '0);
      advance();
      s_ack = 1'b1;
      advance();
      s_ack = 1'b0;
      set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
      advance();
      advance();
    end

    // Dead slave under m0: err in the 4th unacked strobe cycle, then again.
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h500, '0);
    for (int k = 0; k < 10; k++) advance();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    advance();
    advance();

    // Ack arriving in the would-be timeout cycle wins over err.
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h600, '0);
    for (int k = 0; k < 4; k++) advance();
    s_ack = 1'b1;
    advance();
    s_ack = 1'b0;
    advance();
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    advance();
    advance();

    // Reset mid-burst drops everything at once; request regranted after.
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h700, 32'h7);
    advance();
    advance();
    rst_n = 1'b0;
    model_reset();
    advance();
    rst_n = 1'b1;
    advance();
    advance();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    advance();

    // Randomized traffic with bursts, idle gaps and dead-slave phases.
    dead = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 80 == 0) dead = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 2; i++) begin
        if (cy[i]) cy[i] = ($urandom_range(0, 9) != 0);
        else       cy[i] = ($urandom_range(0, 3) == 0);
        st[i] = cy[i] && ($urandom_range(0, 3) != 0);
        a[i]  = $urandom;
        d[i]  = $urandom;
        w[i]  = 1'($urandom_range(0, 1));
        sl[i] = 4'($urandom_range(0, 15));
      end
      s_ack = !dead && ($urandom_range(0, 2) == 0);
      s_dat = $urandom;
      advance();
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions unchecked, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
